multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 185 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for a multicycle RV32-style datapath.
// State is registered; datapath selects and strobes are decoded from the
// registered state (FETCH/BEQ strobes also follow mem_ready/zero).
// A wait counter bounds every memory wait; on expiry bus_err pulses and the
// FSM restarts at FETCH.
// Optional feature: define MULTICYCLE_ILLEGAL_TRAP_EN to send illegal opcodes
// to a TRAP state that holds until reset (otherwise they return to FETCH).
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       bus_err,
  output logic [3:0] state
);

  localparam int unsigned   CW    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    , S_TRAP   = 4'd11
`endif
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_cnt_d;
  logic          in_wait;
  logic          timeout;

  // Next-state and wait-counter logic; timeout overrides the normal wait.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt;
    in_wait    = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                 (state_q == S_MEMWRITE);
    timeout    = in_wait && !mem_ready && (wait_cnt == LIMIT);

    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BEQ;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase

    if (timeout) state_d = S_FETCH;

    // A timeout from FETCH re-enters FETCH, so it must also clear the count.
    if ((state_d != state_q) || timeout)
      wait_cnt_d = '0;
    else if (in_wait && !mem_ready && (wait_cnt != '1))
      wait_cnt_d = wait_cnt + 1'b1;
  end

  // State and wait-counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_cnt_d;
    end
  end

  // Datapath selects and strobes decoded from the registered state.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: reg_write = 1'b1;
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = zero;
      end
      default: ;
    endcase
  end

  // Reset takes precedence over a coincident timeout.
  assign bus_err = timeout && !rst;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table vectors, directed corner sequences and a
// randomized run against a behavioural model of the controller.
module tb_multicycle_controller;

  localparam int TMO = 16;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] ILL = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, mem_write, reg_write, adr_src, bus_err;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic [3:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_controller #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_write(mem_write),
    .reg_write(reg_write), .adr_src(adr_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .alu_op(alu_op),
    .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  // Output vector layout: {state, pc, ir, mw, rw, adr, a, b, res, alu, bus_err}
  function automatic logic [17:0] E(int st, bit pc, bit ir, bit mw, bit rw,
                                    bit adr, bit [1:0] a, bit [1:0] b,
                                    bit [1:0] res, bit [1:0] alu);
    return {4'(st), pc, ir, mw, rw, adr, a, b, res, alu, 1'b0};
  endfunction

  // Expected outputs for each state number, straight from the state table.
  function automatic logic [17:0] model_out(int s, bit mr, bit z);
    case (s)
      0:  return E(0,  mr, mr, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00);
      1:  return E(1,  0,  0,  0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00);
      2:  return E(2,  0,  0,  0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00);
      3:  return E(3,  0,  0,  0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
      4:  return E(4,  0,  0,  0, 1, 0, 2'b00, 2'b00, 2'b01, 2'b00);
      5:  return E(5,  0,  0,  1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
      6:  return E(6,  0,  0,  0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b10);
      7:  return E(7,  0,  0,  0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b10);
      8:  return E(8,  0,  0,  0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
      9:  return E(9,  1,  0,  0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00);
      10: return E(10, z,  0,  0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b01);
      11: return E(11, 0,  0,  0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
      default: return '1;
    endcase
  endfunction

  function automatic int decode_next(logic [6:0] o);
    case (o)
      LW, SW: return 2;
      RT:     return 6;
      IT:     return 7;
      JL:     return 9;
      BQ:     return 10;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      default: return 11;
`else
      default: return 0;
`endif
    endcase
  endfunction

  function automatic logic [17:0] dut_vec();
    return {state, pc_write, ir_write, mem_write, reg_write, adr_src,
            alu_src_a, alu_src_b, result_src, alu_op, bus_err};
  endfunction

  // Drive inputs away from the active edge, then compare outputs.
  task automatic step(input string name, input logic r, input logic [6:0] o,
                      input logic z, input logic mr, input logic [17:0] exp);
    logic [17:0] got;
    @(negedge clk);
    rst = r; op = o; zero = z; mem_ready = mr;
    #1;
    got = dut_vec();
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got st=%0d vec=%05h, expected st=%0d vec=%05h",
               name, $time, got[17:14], got, exp[17:14], exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; op = '0;
  endtask

  typedef struct {
    logic        r;
    logic [6:0]  o;
    logic        z;
    logic        mr;
    logic [17:0] exp;
  } vec_t;

  function automatic vec_t mk(logic r, logic [6:0] o, logic z, logic mr,
                              logic [17:0] exp);
    vec_t v;
    v.r = r; v.o = o; v.z = z; v.mr = mr; v.exp = exp;
    return v;
  endfunction

  vec_t tbl[$];
  logic [17:0] be_bit;
  logic [6:0]  ops [8];

  initial begin
    be_bit = 18'h00001;
    ops = '{LW, SW, RT, IT, JL, BQ, ILL, 7'h00};

    // ---- table-driven instruction walks ----
    tbl.push_back(mk(0, LW, 0, 0, model_out(0, 0, 0)));  // reset state
    tbl.push_back(mk(0, LW, 0, 1, model_out(0, 1, 0)));  // lw
    tbl.push_back(mk(0, LW, 0, 1, model_out(1, 0, 0)));
    tbl.push_back(mk(0, LW, 0, 1, model_out(2, 0, 0)));
    tbl.push_back(mk(0, LW, 0, 1, model_out(3, 0, 0)));
    tbl.push_back(mk(0, LW, 0, 1, model_out(4, 0, 0)));
    tbl.push_back(mk(0, SW, 0, 0, model_out(0, 0, 0)));
    tbl.push_back(mk(0, SW, 0, 1, model_out(0, 1, 0)));  // sw
    tbl.push_back(mk(0, SW, 0, 1, model_out(1, 0, 0)));
    tbl.push_back(mk(0, SW, 0, 1, model_out(2, 0, 0)));
    tbl.push_back(mk(0, SW, 0, 0, model_out(5, 0, 0)));
    tbl.push_back(mk(0, SW, 0, 0, model_out(5, 0, 0)));
    tbl.push_back(mk(0, SW, 0, 0, model_out(5, 0, 0)));
    tbl.push_back(mk(0, SW, 0, 1, model_out(5, 1, 0)));
    tbl.push_back(mk(0, BQ, 1, 1, model_out(0, 1, 1)));  // beq taken
    tbl.push_back(mk(0, BQ, 1, 1, model_out(1, 0, 1)));
    tbl.push_back(mk(0, BQ, 1, 1, E(10, 1, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b01)));
    tbl.push_back(mk(0, BQ, 0, 1, model_out(0, 1, 0)));  // beq not taken
    tbl.push_back(mk(0, BQ, 0, 1, model_out(1, 0, 0)));
    tbl.push_back(mk(0, BQ, 0, 1, E(10, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b01)));
    tbl.push_back(mk(0, RT, 0, 1, model_out(0, 1, 0)));  // R-type
    tbl.push_back(mk(0, RT, 0, 1, model_out(1, 0, 0)));
    tbl.push_back(mk(0, RT, 0, 1, model_out(6, 0, 0)));
    tbl.push_back(mk(0, RT, 0, 1, model_out(8, 0, 0)));
    tbl.push_back(mk(0, IT, 0, 1, model_out(0, 1, 0)));  // I-type
    tbl.push_back(mk(0, IT, 0, 0, model_out(1, 0, 0)));
    tbl.push_back(mk(0, IT, 0, 0, model_out(7, 0, 0)));
    tbl.push_back(mk(0, IT, 0, 0, model_out(8, 0, 0)));
    tbl.push_back(mk(0, JL, 0, 1, model_out(0, 1, 0)));  // jal
    tbl.push_back(mk(0, JL, 0, 0, model_out(1, 0, 0)));
    tbl.push_back(mk(0, JL, 0, 0, model_out(9, 0, 0)));
    tbl.push_back(mk(0, JL, 0, 0, model_out(8, 0, 0)));
    tbl.push_back(mk(0, JL, 0, 0, model_out(0, 0, 0)));

    do_reset();
    foreach (tbl[i]) step("table", tbl[i].r, tbl[i].o, tbl[i].z, tbl[i].mr, tbl[i].exp);

    // ---- FETCH timeout: single bus_err pulse on the 16th idle cycle ----
    do_reset();
    for (int i = 0; i < TMO; i++)
      step("fetch_timeout", 0, LW, 0, 0, model_out(0, 0, 0) | ((i == TMO - 1) ? be_bit : '0));
    step("fetch_after_timeout", 0, LW, 0, 0, model_out(0, 0, 0));

    // ---- mem_ready wins in the timeout cycle ----
    do_reset();
    for (int i = 0; i < TMO - 1; i++) step("ready_wins_wait", 0, LW, 0, 0, model_out(0, 0, 0));
    step("ready_wins_edge", 0, LW, 0, 1, model_out(0, 1, 0));
    step("ready_wins_next", 0, LW, 0, 0, model_out(1, 0, 0));

    // ---- MEMREAD timeout returns to FETCH without reg_write ----
    do_reset();
    step("mr_tmo_f", 0, LW, 0, 1, model_out(0, 1, 0));
    step("mr_tmo_d", 0, LW, 0, 0, model_out(1, 0, 0));
    step("mr_tmo_a", 0, LW, 0, 0, model_out(2, 0, 0));
    for (int i = 0; i < TMO; i++)
      step("memread_timeout", 0, LW, 0, 0, model_out(3, 0, 0) | ((i == TMO - 1) ? be_bit : '0));
    step("memread_after_timeout", 0, LW, 0, 0, model_out(0, 0, 0));

    // ---- reset mid-MEMWRITE ----
    do_reset();
    step("rst_mw_f", 0, SW, 0, 1, model_out(0, 1, 0));
    step("rst_mw_d", 0, SW, 0, 0, model_out(1, 0, 0));
    step("rst_mw_a", 0, SW, 0, 0, model_out(2, 0, 0));
    step("rst_mw_in", 1, SW, 0, 0, model_out(5, 0, 0));
    step("rst_mw_after", 0, SW, 0, 0, model_out(0, 0, 0));

    // ---- reset in EXECR: no reg_write ever ----
    do_reset();
    step("rst_ex_f", 0, RT, 0, 1, model_out(0, 1, 0));
    step("rst_ex_d", 0, RT, 0, 0, model_out(1, 0, 0));
    step("rst_ex_in", 1, RT, 0, 0, model_out(6, 0, 0));
    step("rst_ex_after", 0, RT, 0, 0, model_out(0, 0, 0));
    step("rst_ex_after2", 0, RT, 0, 0, model_out(0, 0, 0));

    // ---- illegal opcode ----
    do_reset();
    step("ill_f", 0, ILL, 0, 1, model_out(0, 1, 0));
    step("ill_d", 0, ILL, 0, 0, model_out(1, 0, 0));
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    for (int i = 0; i < 4; i++) step("ill_trap_hold", 0, ILL, 1, 1'(i), model_out(11, 0, 0));
    step("ill_trap_rst", 1, ILL, 0, 0, model_out(11, 0, 0));
    step("ill_trap_exit", 0, ILL, 0, 0, model_out(0, 0, 0));
`else
    step("ill_to_fetch", 0, ILL, 0, 0, model_out(0, 0, 0));
`endif

    // ---- randomized run against the behavioural model ----
    begin
      int st_m = 0;
      int w_m = 0;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
        int thr, ns;
        bit r, z, m, in_wait, tmo;
        logic [6:0] o;
        thr = ((i / 500) % 3 == 0) ? 90 : (((i / 500) % 3 == 1) ? 50 : 8);
        r = ($urandom_range(0, 39) == 0);
        o = ops[$urandom_range(0, 7)];
        if (o == 7'h00) o = 7'($urandom());
        z = 1'($urandom_range(0, 1));
        m = ($urandom_range(0, 99) < thr);
        in_wait = (st_m == 0) || (st_m == 3) || (st_m == 5);
        tmo = in_wait && !m && (w_m == TMO - 1);
        step("random", r, o, z, m, model_out(st_m, m, z) | ((tmo && !r) ? be_bit : '0));
        case (st_m)
          0:  ns = m ? 1 : 0;
          1:  ns = decode_next(o);
          2:  ns = o[5] ? 5 : 3;
          3:  ns = m ? 4 : 3;
          5:  ns = m ? 0 : 5;
          6, 7, 9: ns = 8;
          11: ns = 11;
          default: ns = 0;
        endcase
        if (tmo) ns = 0;
        if (r) begin
          st_m = 0; w_m = 0;
        end else begin
          if (ns != st_m || tmo) w_m = 0;
          else if (in_wait && !m) w_m++;
          st_m = ns;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
